// File: rtl/mult_sequencer_pkg.sv
// Shared definitions for the iterative multiply sequencer: state encoding,
// default operand width and the iteration counter width helper.
package mult_sequencer_pkg;

  localparam int WIDTH_DEF = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  // One counter value per operand bit; a floor of 1 bit keeps tiny widths legal.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

  localparam int CNT_W_DEF = cnt_width(WIDTH_DEF);

endpackage

// File: rtl/mult_datapath.sv
// Operand magnitude capture, shift-add accumulator and sign fix-up; one operand bit per step.
// No handshake: acts only on load/step/fix strobes from the sequencer FSM.
module mult_datapath
  import mult_sequencer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk1_i,
  input  logic             reset_i,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             fix_i,
  input  logic             signed_op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [WIDTH-1:0]   mcand_q, mplier_q;
  logic               neg_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   hi_q, lo_q;

  logic [WIDTH-1:0]   mag_a, mag_b, addend;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH:0]   wide;
  logic [2*WIDTH-1:0] acc_d, result;

  always_comb begin
    // Most-negative operand maps to its unsigned magnitude with no overflow.
    mag_a  = (signed_op_i && a_i[WIDTH-1]) ? (~a_i + WIDTH'(1)) : a_i;
    mag_b  = (signed_op_i && b_i[WIDTH-1]) ? (~b_i + WIDTH'(1)) : b_i;
    addend = mplier_q[0] ? mcand_q : '0;
    sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    wide   = {sum, acc_q[WIDTH-1:0]};
    acc_d  = wide[2*WIDTH:1];
    result = neg_q ? (~acc_q + (2*WIDTH)'(1)) : acc_q;
  end

  always_ff @(posedge clk1_i or posedge reset_i) begin
    if (reset_i) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      if (load_i) begin
        mcand_q  <= mag_a;
        mplier_q <= mag_b;
        neg_q    <= signed_op_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
        acc_q    <= '0;
      end else if (step_i) begin
        acc_q    <= acc_d;
        mplier_q <= mplier_q >> 1;
      end
      if (fix_i) begin
        hi_q <= result[2*WIDTH-1:WIDTH];
        lo_q <= result[WIDTH-1:0];
      end
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: rtl/mult_sequencer.sv
// IDLE/RUN/FIX control for the shift-add multiplier; start-edge to done pulse is WIDTH+1 cycles.
// start is sampled only in IDLE and ignored while busy; done pulses for exactly one cycle.
module mult_sequencer
  import mult_sequencer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk1_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             signed_op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CNT_W = cnt_width(WIDTH);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             load, step, fix;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    step    = 1'b0;
    fix     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        step = 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          cnt_d   = '0;
          state_d = ST_FIX;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_FIX: begin
        fix     = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    done_d = fix;
  end

  always_ff @(posedge clk1_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  mult_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk1_i      (clk1_i),
    .reset_i     (reset_i),
    .load_i      (load),
    .step_i      (step),
    .fix_i       (fix),
    .signed_op_i (signed_op_i),
    .a_i         (a_i),
    .b_i         (b_i),
    .hi_o        (hi_o),
    .lo_o        (lo_o)
  );

  assign busy_o = (state_q != ST_IDLE);
  assign done_o = done_q;

endmodule

// File: tb/tb_mult_sequencer.sv
// Directed checks of mult_sequencer: latency, signed/unsigned products,
// boundary operands, start-while-busy, back-to-back and mid-run reset.
module tb_mult_sequencer;

  logic        clk1 = 1'b0;
  logic        reset;
  logic        start;
  logic        signed_op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi, lo;

  int errors = 0;
  int checks = 0;

  mult_sequencer #(.WIDTH(32)) dut (
    .clk1_i      (clk1),
    .reset_i     (reset),
    .start_i     (start),
    .signed_op_i (signed_op),
    .a_i         (a),
    .b_i         (b),
    .busy_o      (busy),
    .done_o      (done),
    .hi_o        (hi),
    .lo_o        (lo)
  );

  always #5 clk1 = ~clk1;

  // Present a request and let it be captured on the next edge (edge 0).
  task automatic launch(input logic [31:0] av, input logic [31:0] bv, input logic s);
    a = av; b = bv; signed_op = s; start = 1'b1;
    @(posedge clk1); #1;
    start = 1'b0;
  endtask

  // Count edges until done is seen; returns -1 if it never arrives within budget.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (1) begin
      @(posedge clk1); #1;
      cyc++;
      if (done) break;
      if (cyc > 60) begin cyc = -1; break; end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; signed_op = 1'b0; a = '0; b = '0;
    @(posedge clk1); @(posedge clk1); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h want 00000000", hi); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h want 00000000", lo); end
    reset = 1'b0;
    @(posedge clk1); #1;
  endtask

  task automatic test_unsigned;
    int cyc;
    launch(32'd3, 32'd5, 1'b0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL u3x5_busy_after_start: got %b want 1", busy); end
    wait_done(cyc);
    checks++; if (cyc !== 33) begin errors++; $display("FAIL u3x5_latency: got %0d want 33", cyc); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL u3x5_hi: got %h want 00000000", hi); end
    checks++; if (lo !== 32'hF) begin errors++; $display("FAIL u3x5_lo: got %h want 0000000f", lo); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL u3x5_busy_in_done: got %b want 0", busy); end
    @(posedge clk1); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL u3x5_done_one_cycle: got %b want 0", done); end
    checks++; if (lo !== 32'hF) begin errors++; $display("FAIL u3x5_lo_hold: got %h want 0000000f", lo); end

    launch(32'h8000_0000, 32'd2, 1'b0);
    wait_done(cyc);
    checks++; if (hi !== 32'h1 || lo !== 32'h0) begin errors++; $display("FAIL u80000000x2: got %h_%h want 00000001_00000000", hi, lo); end
  endtask

  task automatic test_signed;
    int cyc;
    launch(32'hFFFF_FFFD, 32'd5, 1'b1);
    wait_done(cyc);
    checks++; if (cyc !== 33) begin errors++; $display("FAIL sm3x5_latency: got %0d want 33", cyc); end
    checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sm3x5_hi: got %h want ffffffff", hi); end
    checks++; if (lo !== 32'hFFFF_FFF1) begin errors++; $display("FAIL sm3x5_lo: got %h want fffffff1", lo); end

    launch(32'd7, 32'hFFFF_FFFF, 1'b1);
    wait_done(cyc);
    checks++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFF9) begin errors++; $display("FAIL s7xm1: got %h_%h want ffffffff_fffffff9", hi, lo); end
  endtask

  task automatic test_boundary;
    int cyc;
    launch(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    wait_done(cyc);
    checks++; if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin errors++; $display("FAIL u_max_sq: got %h_%h want fffffffe_00000001", hi, lo); end

    launch(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    wait_done(cyc);
    checks++; if (hi !== 32'h0 || lo !== 32'h1) begin errors++; $display("FAIL s_m1_sq: got %h_%h want 00000000_00000001", hi, lo); end

    launch(32'h8000_0000, 32'h8000_0000, 1'b1);
    wait_done(cyc);
    checks++; if (hi !== 32'h4000_0000 || lo !== 32'h0) begin errors++; $display("FAIL s_minneg_sq: got %h_%h want 40000000_00000000", hi, lo); end
  endtask

  task automatic test_back_to_back;
    int cyc;
    launch(32'd7, 32'd9, 1'b0);
    repeat (9) @(posedge clk1);
    #1;
    a = 32'd100; b = 32'd100; signed_op = 1'b1; start = 1'b1;
    @(posedge clk1); #1;
    start = 1'b0; a = 32'h1234_5678; b = 32'h9ABC_DEF0;
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL ign_start_state: got busy=%b done=%b want busy=1 done=0", busy, done); end
    wait_done(cyc);
    checks++; if (cyc !== 23) begin errors++; $display("FAIL ign_latency_rest: got %0d want 23", cyc); end
    checks++; if (hi !== 32'h0 || lo !== 32'd63) begin errors++; $display("FAIL ign_7x9: got %h_%h want 00000000_0000003f", hi, lo); end

    a = 32'd6; b = 32'd7; signed_op = 1'b0; start = 1'b1;
    @(posedge clk1); #1;
    start = 1'b0;
    checks++; if (done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: got busy=%b done=%b want busy=1 done=0", busy, done); end
    wait_done(cyc);
    checks++; if (cyc !== 33) begin errors++; $display("FAIL b2b_latency: got %0d want 33", cyc); end
    checks++; if (hi !== 32'h0 || lo !== 32'd42) begin errors++; $display("FAIL b2b_6x7: got %h_%h want 00000000_0000002a", hi, lo); end
  endtask

  task automatic test_reset_mid;
    int cyc;
    int pulses;
    launch(32'd11, 32'd13, 1'b0);
    repeat (14) @(posedge clk1);
    #3;
    reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midrst_ctrl: got busy=%b done=%b want 0 0", busy, done); end
    checks++; if (hi !== 32'h0 || lo !== 32'h0) begin errors++; $display("FAIL midrst_hilo: got %h_%h want 00000000_00000000", hi, lo); end
    repeat (2) @(posedge clk1);
    #3;
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk1); #1;
      if (done) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL midrst_no_done: got %0d pulses want 0", pulses); end
    launch(32'd2, 32'd2, 1'b0);
    wait_done(cyc);
    checks++; if (cyc !== 33) begin errors++; $display("FAIL post_rst_latency: got %0d want 33", cyc); end
    checks++; if (hi !== 32'h0 || lo !== 32'd4) begin errors++; $display("FAIL post_rst_2x2: got %h_%h want 00000000_00000004", hi, lo); end
  endtask

  initial begin
    test_reset;
    test_unsigned;
    test_signed;
    test_boundary;
    test_back_to_back;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
